// File: rtl/cjb_nbit_logic_unit_seq_v_if.sv
// Request/result handshake bundle for the sequential N-bit logic unit.
// master = requester/consumer side, slave = the logic unit itself.
interface cjb_nbit_logic_unit_seq_v_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned K_WIDTH = 3
);
  logic               In_Valid;
  logic               In_Ready;
  logic [2:0]         Func_Sel;
  logic [WIDTH-1:0]   Operand_X;
  logic [WIDTH-1:0]   Operand_Y;
  logic [K_WIDTH-1:0] Const_K;
  logic               Out_Valid;
  logic               Out_Ready;
  logic [WIDTH-1:0]   Logic_Result;
  logic [3:0]         Logic_CNVZ;

  modport master (
    output In_Valid, Func_Sel, Operand_X, Operand_Y, Const_K, Out_Ready,
    input  In_Ready, Out_Valid, Logic_Result, Logic_CNVZ
  );

  modport slave (
    input  In_Valid, Func_Sel, Operand_X, Operand_Y, Const_K, Out_Ready,
    output In_Ready, Out_Valid, Logic_Result, Logic_CNVZ
  );
endinterface

// File: rtl/cjb_nbit_logic_unit_seq_v.sv
// Sequential N-bit logic unit: single-cycle bitwise ops, bit-serial rotates,
// registered result plus {C,N,V,Z} held until the consumer takes it.
module cjb_nbit_logic_unit_seq_v #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned K_WIDTH = 3
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  cjb_nbit_logic_unit_seq_v_if.slave    bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;

  localparam logic [2:0] FN_XOR  = 3'b000;
  localparam logic [2:0] FN_AND  = 3'b001;
  localparam logic [2:0] FN_OR   = 3'b010;
  localparam logic [2:0] FN_PASS = 3'b011;
  localparam logic [2:0] FN_NOT  = 3'b100;
  localparam logic [2:0] FN_XNOR = 3'b101;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_cnvz;
  logic [K_WIDTH-1:0] r_cnt;
  logic               r_dir_right;

  logic               w_accept;
  logic               w_is_rot;
  logic               w_serial;
  logic [WIDTH-1:0]   w_comb_res;
  logic [WIDTH-1:0]   w_rot_next;
  logic               w_rot_carry;

  assign w_accept = (r_state == IDLE) && bus.In_Valid;
  assign w_is_rot = (bus.Func_Sel[2:1] == 2'b11);
  // A zero-count rotate is a plain pass-through and completes in one cycle.
  assign w_serial = w_is_rot && (bus.Const_K != '0);

  always_comb begin
    w_comb_res = bus.Operand_X;
    case (bus.Func_Sel)
      FN_XOR:  w_comb_res = bus.Operand_X ^ bus.Operand_Y;
      FN_AND:  w_comb_res = bus.Operand_X & bus.Operand_Y;
      FN_OR:   w_comb_res = bus.Operand_X | bus.Operand_Y;
      FN_PASS: w_comb_res = bus.Operand_X;
      FN_NOT:  w_comb_res = ~bus.Operand_X;
      FN_XNOR: w_comb_res = ~(bus.Operand_X ^ bus.Operand_Y);
      default: w_comb_res = bus.Operand_X;
    endcase
  end

  always_comb begin
    if (r_dir_right) begin
      w_rot_next  = {r_work[0], r_work[WIDTH-1:1]};
      w_rot_carry = r_work[0];
    end else begin
      w_rot_next  = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
      w_rot_carry = r_work[WIDTH-1];
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_result    <= '0;
      r_cnvz      <= 4'b0000;
      r_cnt       <= '0;
      r_dir_right <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_serial) begin
              r_work      <= bus.Operand_X;
              r_cnt       <= bus.Const_K;
              r_dir_right <= bus.Func_Sel[0];
              r_state     <= BUSY;
            end else begin
              r_result <= w_comb_res;
              r_cnvz   <= {1'b0, w_comb_res[WIDTH-1], 1'b0, (w_comb_res == '0)};
              r_state  <= HOLD;
            end
          end
        end
        BUSY: begin
          r_work <= w_rot_next;
          r_cnt  <= r_cnt - K_WIDTH'(1);
          // Result and flags only publish on the final shift.
          if (r_cnt == K_WIDTH'(1)) begin
            r_result <= w_rot_next;
            r_cnvz   <= {w_rot_carry, w_rot_next[WIDTH-1], 1'b0, (w_rot_next == '0)};
            r_state  <= HOLD;
          end
        end
        HOLD: begin
          if (bus.Out_Ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.In_Ready     = (r_state == IDLE);
  assign bus.Out_Valid    = (r_state == HOLD);
  assign bus.Logic_Result = r_result;
  assign bus.Logic_CNVZ   = r_cnvz;

endmodule

// File: tb/tb_cjb_nbit_logic_unit_seq_v.sv
// Bench for cjb_nbit_logic_unit_seq_v: directed cases plus random operations
// against an arithmetic reference model, on an 8-bit and a 16-bit instance.
module tb_cjb_nbit_logic_unit_seq_v;

  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  cjb_nbit_logic_unit_seq_v_if #(.WIDTH(8),  .K_WIDTH(3)) bus8 ();
  cjb_nbit_logic_unit_seq_v_if #(.WIDTH(16), .K_WIDTH(4)) bus16 ();

  cjb_nbit_logic_unit_seq_v #(.WIDTH(8), .K_WIDTH(3)) dut8 (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus8)
  );

  cjb_nbit_logic_unit_seq_v #(.WIDTH(16), .K_WIDTH(4)) dut16 (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus16)
  );

  logic        sel16;
  logic        iv;
  logic        ordy;
  logic [2:0]  fs;
  logic [15:0] x;
  logic [15:0] y;
  logic [3:0]  k;

  assign bus8.In_Valid   = iv & ~sel16;
  assign bus8.Func_Sel   = fs;
  assign bus8.Operand_X  = x[7:0];
  assign bus8.Operand_Y  = y[7:0];
  assign bus8.Const_K    = k[2:0];
  assign bus8.Out_Ready  = ordy;
  assign bus16.In_Valid  = iv & sel16;
  assign bus16.Func_Sel  = fs;
  assign bus16.Operand_X = x;
  assign bus16.Operand_Y = y;
  assign bus16.Const_K   = k;
  assign bus16.Out_Ready = ordy;

  logic        ob_valid;
  logic        ob_ready;
  logic [15:0] ob_res;
  logic [3:0]  ob_cnvz;
  assign ob_valid = sel16 ? bus16.Out_Valid : bus8.Out_Valid;
  assign ob_ready = sel16 ? bus16.In_Ready  : bus8.In_Ready;
  assign ob_res   = sel16 ? bus16.Logic_Result : {8'h00, bus8.Logic_Result};
  assign ob_cnvz  = sel16 ? bus16.Logic_CNVZ : bus8.Logic_CNVZ;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] last_res  [2];
  logic [3:0]  last_cnvz [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    iv = 1'($urandom);
    fs = 3'($urandom);
    x  = 16'($urandom);
    y  = 16'($urandom);
    k  = 4'($urandom);
  endtask

  // Issue one request, follow it through BUSY/HOLD, then release it.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [15:0] ox,
                       input logic [15:0] oy, input int ok, input int hold);
    int unsigned w, mask, xv, yv, r, kk, kv;
    int          exp_lat, n;
    logic        c, nb, zb;
    logic [3:0]  exp_cnvz;
    w    = sel16 ? 16 : 8;
    mask = (32'd1 << w) - 1;
    kv   = ok & (sel16 ? 15 : 7);
    xv   = ox & mask;
    yv   = oy & mask;
    kk   = kv % w;
    case (f)
      3'd0: r = xv ^ yv;
      3'd1: r = xv & yv;
      3'd2: r = xv | yv;
      3'd3: r = xv;
      3'd4: r = ~xv;
      3'd5: r = ~(xv ^ yv);
      3'd6: r = (xv << kk) | (xv >> (w - kk));
      default: r = (xv >> kk) | (xv << (w - kk));
    endcase
    r  &= mask;
    c  = (f == 3'd6 && kv > 0) ? r[0] :
         (f == 3'd7 && kv > 0) ? 1'((r >> (w - 1)) & 1) : 1'b0;
    nb = 1'((r >> (w - 1)) & 1);
    zb = (r == 0);
    exp_cnvz = {c, nb, 1'b0, zb};
    exp_lat  = (f[2:1] == 2'b11 && kv > 0) ? int'(kv) + 1 : 1;

    @(negedge Clock);
    check({tag, "_in_ready_idle"}, 32'(ob_ready), 32'd1);
    iv = 1'b1; fs = f; x = ox; y = oy; k = 4'(ok);
    @(negedge Clock);
    n = 1;
    scramble();
    while (!ob_valid && n < 40) begin
      check({tag, "_busy_res_held"}, 32'(ob_res), 32'(last_res[sel16]));
      check({tag, "_busy_in_ready"}, 32'(ob_ready), 32'd0);
      @(negedge Clock);
      n++;
      scramble();
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_result"}, 32'(ob_res), r);
    check({tag, "_cnvz"}, 32'(ob_cnvz), 32'(exp_cnvz));
    last_res[sel16]  = 16'(r);
    last_cnvz[sel16] = exp_cnvz;
    repeat (hold) begin
      @(negedge Clock);
      check({tag, "_hold_valid"}, 32'(ob_valid), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(ob_ready), 32'd0);
      check({tag, "_hold_result"}, 32'(ob_res), r);
      check({tag, "_hold_cnvz"}, 32'(ob_cnvz), 32'(exp_cnvz));
      scramble();
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(negedge Clock);
    ordy = 1'b0;
    check({tag, "_done_valid"}, 32'(ob_valid), 32'd0);
    check({tag, "_done_in_ready"}, 32'(ob_ready), 32'd1);
  endtask

  initial begin
    Resetn = 1'b0;
    sel16 = 1'b0; iv = 1'b0; ordy = 1'b0; fs = '0; x = '0; y = '0; k = '0;
    last_res[0] = '0; last_res[1] = '0; last_cnvz[0] = '0; last_cnvz[1] = '0;
    #3;
    check("rst_valid", 32'(ob_valid), 32'd0);
    check("rst_ready", 32'(ob_ready), 32'd1);
    check("rst_result", 32'(ob_res), 32'd0);
    check("rst_cnvz", 32'(ob_cnvz), 32'd0);
    check("rst16_result", 32'(bus16.Logic_Result), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    do_op("and",   3'b001, 16'h00F0, 16'h003C, 0, 5);
    do_op("xor",   3'b000, 16'h00A5, 16'h00A5, 0, 0);
    do_op("xnor",  3'b101, 16'h00A5, 16'h00A5, 0, 1);
    do_op("rol3",  3'b110, 16'h00E0, 16'h0000, 3, 2);
    do_op("ror1",  3'b111, 16'h0001, 16'h0000, 1, 0);
    do_op("rol0",  3'b110, 16'h005A, 16'h0000, 0, 1);
    do_op("not",   3'b100, 16'h00FF, 16'h0000, 0, 0);
    do_op("rol7",  3'b110, 16'h0081, 16'h0000, 7, 0);

    // Abort a long rotate partway through with an asynchronous reset.
    @(negedge Clock);
    iv = 1'b1; fs = 3'b110; x = 16'h0033; k = 4'd7;
    @(negedge Clock);
    iv = 1'b0;
    repeat (2) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    check("midrst_valid", 32'(ob_valid), 32'd0);
    check("midrst_result", 32'(ob_res), 32'd0);
    check("midrst_cnvz", 32'(ob_cnvz), 32'd0);
    check("midrst_ready", 32'(ob_ready), 32'd1);
    @(negedge Clock);
    Resetn = 1'b1;
    last_res[0] = '0; last_cnvz[0] = '0;
    last_res[1] = '0; last_cnvz[1] = '0;
    repeat (10) begin
      @(negedge Clock);
      check("postrst_no_valid", 32'(ob_valid), 32'd0);
      check("postrst_ready", 32'(ob_ready), 32'd1);
    end
    do_op("after_rst", 3'b010, 16'h0012, 16'h0040, 0, 0);

    for (int i = 0; i < 40; i++) begin
      do_op("rnd8", 3'($urandom), 16'($urandom), 16'($urandom),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    sel16 = 1'b1;
    do_op("ror16_k15", 3'b111, 16'h0001, 16'h0000, 15, 1);
    for (int i = 0; i < 12; i++) begin
      do_op("rnd16", 3'($urandom), 16'($urandom), 16'($urandom),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
